uart_rx_framed: RTL and testbench

//   Parametrised oversampling UART receiver: the successor to the fixed 8N2 receiver.

---
 rtl/uart_rx_framed.sv | 190 +++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampling UART receiver with start-glitch rejection, framing/overrun
// flags and a valid/ready output. Define UART_RX_PARITY_EN to add a parity bit and o_parity_err.
module uart_rx_framed #(
    parameter int DATA       = 8,
    parameter int STOP       = 1,
    parameter int OSR        = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic            i_divided_clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic            i_rx,
    input  logic            i_ready,
    output logic [DATA-1:0] o_data,
    output logic            o_valid,
    output logic            o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic            o_parity_err,
`endif
    output logic            o_overrun,
    output logic            o_busy
);

    if (DATA < 5 || DATA > 9 || STOP < 1 || STOP > 2 || OSR < 4 || (OSR % 2) != 0 ||
        PARITY_ODD < 0 || PARITY_ODD > 1)
        $error("uart_rx_framed: illegal parameter set");

    localparam int TW = $clog2(OSR);
    localparam int BW = $clog2(DATA + 1);
    localparam logic [TW-1:0] T_MID  = TW'(OSR / 2 - 1);
    localparam logic [TW-1:0] T_LAST = TW'(OSR - 1);
    localparam logic [BW-1:0] B_DATA = BW'(DATA - 1);
    localparam logic [BW-1:0] B_STOP = BW'(STOP - 1);
`ifdef UART_RX_PARITY_EN
    localparam logic ODD = (PARITY_ODD != 0);
`endif

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA_BITS,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP_BITS
    } state_t;

    state_t          state;
    logic [TW-1:0]   tick_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [DATA-1:0] shreg;
    logic            ferr_cap;
    logic            rx_meta;
    logic            rxs;
`ifdef UART_RX_PARITY_EN
    logic            perr_cap;
`endif

    logic commit;
    logic accept;

    // Two-flop synchroniser runs every clock, independent of the oversample tick.
    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rxs     <= rx_meta;
        end
    end

    assign commit = i_en && (state == STOP_BITS) && (tick_cnt == T_LAST) && (bit_cnt == B_STOP);
    assign accept = o_valid && i_ready;

    always_ff @(posedge i_divided_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shreg       <= '0;
            ferr_cap    <= 1'b0;
            o_busy      <= 1'b0;
            o_data      <= '0;
            o_valid     <= 1'b0;
            o_frame_err <= 1'b0;
            o_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_cap     <= 1'b0;
            o_parity_err <= 1'b0;
`endif
        end else begin
            if (i_en) begin
                case (state)
                    IDLE: begin
                        if (!rxs) begin
                            state    <= START;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            o_busy   <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == T_MID) begin
                            // Line back high at mid start bit: a glitch, drop silently.
                            state    <= rxs ? IDLE : DATA_BITS;
                            o_busy   <= !rxs;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    DATA_BITS: begin
                        if (tick_cnt == T_LAST) begin
                            shreg    <= {rxs, shreg[DATA-1:1]};
                            tick_cnt <= '0;
                            if (bit_cnt == B_DATA) begin
                                bit_cnt  <= '0;
                                ferr_cap <= 1'b0;
`ifdef UART_RX_PARITY_EN
                                state    <= PARITY;
`else
                                state    <= STOP_BITS;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tick_cnt == T_LAST) begin
                            perr_cap <= (^{shreg, rxs}) != ODD;
                            state    <= STOP_BITS;
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
`endif
                    STOP_BITS: begin
                        if (tick_cnt == T_LAST) begin
                            tick_cnt <= '0;
                            if (!rxs)
                                ferr_cap <= 1'b1;
                            // Leave at the last stop sample so a following start edge is not missed.
                            if (bit_cnt == B_STOP) begin
                                state   <= IDLE;
                                bit_cnt <= '0;
                                o_busy  <= 1'b0;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        tick_cnt <= '0;
                        bit_cnt  <= '0;
                        o_busy   <= 1'b0;
                    end
                endcase
            end

            // Output handshake runs every clock; a commit needs a free or draining slot.
            if (commit && (!o_valid || i_ready)) begin
                o_data      <= shreg;
                o_frame_err <= ferr_cap | ~rxs;
                o_valid     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                o_parity_err <= perr_cap;
`endif
                if (accept)
                    o_overrun <= 1'b0;
            end else if (commit) begin
                o_overrun <= 1'b1;
            end else if (accept) begin
                o_valid   <= 1'b0;
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Directed + randomized bench for uart_rx_framed; frames are generated at bit level and
// compared with an expected-word queue and a closed-form latency.
module tb_uart_rx_framed;
    localparam int DATA = 8;
    localparam int STOP = 1;
    localparam int OSR  = 16;
    // Pin falling edge to o_valid visible: 2 sync flops + detect clock + frame sample time.
    localparam int LAT  = 3 + OSR / 2 + (DATA + STOP) * OSR;

    logic            clk   = 1'b0;
    logic            rst   = 1'b0;
    logic            en    = 1'b1;
    logic            rx    = 1'b1;
    logic            ready = 1'b1;
    logic [DATA-1:0] data;
    logic            valid;
    logic            ferr;
    logic            ovr;
    logic            busy;

    uart_rx_framed #(.DATA(DATA), .STOP(STOP), .OSR(OSR), .PARITY_ODD(0)) dut (
        .i_divided_clk(clk),
        .i_rst        (rst),
        .i_en         (en),
        .i_rx         (rx),
        .i_ready      (ready),
        .o_data       (data),
        .o_valid      (valid),
        .o_frame_err  (ferr),
        .o_overrun    (ovr),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA-1:0] d;
        logic            fe;
        int              t;
    } word_t;

    word_t exp_q[$];
    word_t got_q[$];
    int    cyc = 0;
    int    rise = 0;
    int    vhi = 0;
    logic  prev_valid = 1'b0;
    int    passes = 0;
    int    total = 0;
    int    en_div = 1;
    int    en_ph = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: records every accepted word with the cycle its o_valid rose.
    always @(negedge clk) begin
        if (valid && !prev_valid)
            rise <= cyc;
        if (valid)
            vhi <= vhi + 1;
        if (valid && ready)
            got_q.push_back('{data, ferr, (valid && !prev_valid) ? cyc : rise});
        prev_valid <= valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (en_div <= 1) begin
                en = 1'b1;
            end else begin
                en_ph = (en_ph + 1) % en_div;
                en    = (en_ph == 0);
            end
        end
    endtask

    task automatic send_frame(input logic [DATA-1:0] d, input logic stopv, input bit expect_it);
        logic [DATA+STOP:0] bits;
        int bl;
        bl   = OSR * en_div;
        bits = {{STOP{stopv}}, d, 1'b0};
        if (expect_it)
            exp_q.push_back('{d, !stopv, cyc});
        for (int i = 0; i < DATA + 1 + STOP; i++) begin
            rx = bits[i];
            tick(bl);
        end
        rx = 1'b1;
    endtask

    task automatic expect_word(input string tag, input bit chk_lat);
        word_t g;
        word_t e;
        int w;
        w = 0;
        while (got_q.size() == 0 && w < 3000) begin
            tick();
            w++;
        end
        check({tag, "_seen"}, 32'(got_q.size() != 0), 32'(1));
        if (got_q.size() != 0 && exp_q.size() != 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_data"}, 32'(g.d), 32'(e.d));
            check({tag, "_ferr"}, 32'(g.fe), 32'(e.fe));
            if (chk_lat)
                check({tag, "_lat"}, 32'(g.t - e.t), 32'(LAT));
        end else if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
        end
    endtask

    initial begin
        logic [DATA-1:0] rd;
        logic            rs;
        int              v0;

        #2 rst = 1'b1;
        tick(3);
        check("rst_valid", 32'(valid), 32'(0));
        check("rst_data",  32'(data),  32'(0));
        check("rst_ferr",  32'(ferr),  32'(0));
        check("rst_ovr",   32'(ovr),   32'(0));
        check("rst_busy",  32'(busy),  32'(0));
        rst = 1'b0;
        tick(5);

        // Good frame, consumer always ready: single-cycle valid pulse.
        v0 = vhi;
        send_frame(8'hA5, 1'b1, 1'b1);
        expect_word("t1", 1'b1);
        tick(2);
        check("t1_pulse", 32'(vhi - v0), 32'(1));
        check("t1_busy",  32'(busy),     32'(0));
        tick(10);

        // Short low glitch on the line is rejected at mid start bit.
        rx = 1'b0;
        tick(4);
        check("t2_busy_hi", 32'(busy), 32'(1));
        rx = 1'b1;
        tick(40);
        check("t2_busy_lo", 32'(busy),          32'(0));
        check("t2_valid",   32'(valid),         32'(0));
        check("t2_ovr",     32'(ovr),           32'(0));
        check("t2_nowords", 32'(got_q.size()),  32'(0));

        // Stop bit low: framing error, then the line recovers to idle.
        send_frame(8'h3C, 1'b0, 1'b1);
        expect_word("t3", 1'b1);
        tick(40);
        check("t3_busy",  32'(busy),  32'(0));
        check("t3_valid", 32'(valid), 32'(0));

        // Back-to-back frames with a stalled consumer: second one dropped.
        ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b1);
        send_frame(8'h22, 1'b1, 1'b0);
        tick(4);
        check("t4_valid", 32'(valid), 32'(1));
        check("t4_data",  32'(data),  32'(8'h11));
        check("t4_ovr",   32'(ovr),   32'(1));
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        tick(1);
        check("t4_valid_clr", 32'(valid), 32'(0));
        check("t4_ovr_clr",   32'(ovr),   32'(0));
        expect_word("t4", 1'b0);
        ready = 1'b1;
        tick(10);

        // Reset in the middle of data bit 3 discards the partial frame.
        rx = 1'b0;
        tick(OSR);
        for (int i = 0; i < 3; i++) begin
            rx = 1'($urandom_range(0, 1));
            tick(OSR);
        end
        rx = 1'b1;
        tick(OSR / 2);
        check("t5_busy_pre", 32'(busy), 32'(1));
        rst = 1'b1;
        tick(2);
        check("t5_rst_valid", 32'(valid), 32'(0));
        check("t5_rst_busy",  32'(busy),  32'(0));
        check("t5_rst_data",  32'(data),  32'(0));
        check("t5_rst_ovr",   32'(ovr),   32'(0));
        rst = 1'b0;
        tick(20);
        check("t5_nowords", 32'(got_q.size()), 32'(0));
        send_frame(8'h81, 1'b1, 1'b1);
        expect_word("t5", 1'b1);
        tick(10);

        // Oversample tick every 4th clock.
        en_div = 4;
        send_frame(8'h5A, 1'b1, 1'b1);
        expect_word("t6a", 1'b0);
        tick(30);
        rd = DATA'($urandom);
        send_frame(rd, 1'b1, 1'b1);
        expect_word("t6b", 1'b0);
        tick(30);
        en_div = 1;
        en     = 1'b1;
        tick(10);

        // Random words and stop-bit values at full tick rate.
        for (int k = 0; k < 8; k++) begin
            rd = DATA'($urandom);
            rs = ($urandom_range(0, 3) != 0);
            send_frame(rd, rs, 1'b1);
            expect_word("rnd", 1'b1);
            tick($urandom_range(24, 60));
        end
        check("end_busy", 32'(busy), 32'(0));
        check("end_ovr",  32'(ovr),  32'(0));

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
